// File: rtl/pattern_capture_sched_if.sv
// Bundle of serial inputs and capture/replay outputs shared between
// pattern_capture_sched and whatever drives or observes it.
interface pattern_capture_sched_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 4
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0]       serial_in;
    logic [LANES*WIDTH-1:0] lane_sr;
    logic [WIDTH-1:0]       replay;
    logic                   replay_valid;
    logic [LW-1:0]          replay_lane;
    logic                   busy;
    logic                   done;
    logic                   dropped;

    modport master (
        output serial_in,
        input  lane_sr, replay, replay_valid, replay_lane, busy, done, dropped
    );

    modport slave (
        input  serial_in,
        output lane_sr, replay, replay_valid, replay_lane, busy, done, dropped
    );
endinterface

// File: rtl/pattern_capture_sched.sv
// Shares one snapshot buffer among LANES serial lanes: a rising edge requests a
// DEPTH-deep capture of that lane's shift register, which is then replayed.
//
// state     | meaning
// S_IDLE    | waiting for a pending request, grants round-robin winner
// S_CAPTURE | writing DEPTH snapshots of the selected lane into the buffer
// S_REPLAY  | driving the buffered snapshots out on replay
// S_DONE    | clearing replay and pulsing done for one cycle
module pattern_capture_sched #(
    parameter int LANES = 4,
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    pattern_capture_sched_if.slave  bus
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_REPLAY  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sr  [LANES];
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [LANES-1:0] r_prev;
    logic [LANES-1:0] r_pend;
    logic [LW-1:0]    r_last;
    logic [LW-1:0]    r_sel;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_replay;
    logic             r_valid;
    logic             r_done;
    logic             r_dropped;

    logic [LANES-1:0] w_edge;
    logic [LANES-1:0] w_clr;
    logic             w_any;
    logic             w_found;
    logic [LW-1:0]    w_winner;
    logic [LW-1:0]    w_idx;

    assign w_edge = bus.serial_in & ~r_prev;
    assign w_any  = |r_pend;

    // Round-robin: first pending lane strictly after the last granted one.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last;
        w_idx    = '0;
        for (int i = 1; i <= LANES; i++) begin
            w_idx = LW'((int'(r_last) + i) % LANES);
            if (!w_found && r_pend[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_clr = (r_state == S_IDLE && w_any) ? (LANES'(1) << w_winner) : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int l = 0; l < LANES; l++) r_sr[l] <= '0;
            r_prev    <= '0;
            r_pend    <= '0;
            r_dropped <= 1'b0;
        end else begin
            for (int l = 0; l < LANES; l++) r_sr[l] <= {r_sr[l][WIDTH-2:0], bus.serial_in[l]};
            r_prev    <= bus.serial_in;
            // A new edge beats a same-cycle grant, so the request is re-queued.
            r_pend    <= (r_pend & ~w_clr) | w_edge;
            r_dropped <= |(w_edge & r_pend & ~w_clr);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state  <= S_IDLE;
            for (int d = 0; d < DEPTH; d++) r_mem[d] <= '0;
            r_last   <= LW'(LANES - 1);
            r_sel    <= '0;
            r_cnt    <= '0;
            r_replay <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_winner;
                        r_last  <= w_winner;
                        r_cnt   <= '0;
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_mem[r_cnt] <= r_sr[r_sel];
                    if (r_cnt == CW'(DEPTH - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_REPLAY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_REPLAY: begin
                    r_replay <= r_mem[r_cnt];
                    r_valid  <= 1'b1;
                    if (r_cnt == CW'(DEPTH - 1)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_replay <= '0;
                    r_valid  <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane_out
        assign bus.lane_sr[l*WIDTH +: WIDTH] = r_sr[l];
    end

    assign bus.replay       = r_replay;
    assign bus.replay_valid = r_valid;
    assign bus.replay_lane  = r_sel;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.done         = r_done;
    assign bus.dropped      = r_dropped;
endmodule
